// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared types and constants for the board I/O controller
package board_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } clk_state_e;

    localparam int DEF_ADDR_W    = 6;
    localparam int DEF_DIV       = 4;
    localparam int DEF_DB_CYCLES = 1_000_000;
    localparam int DEF_WRAP      = 1;
    localparam int DEF_CNT_W     = 16;
    localparam int SYNC_DEPTH    = 2;

    // Counter width for a count of n states; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/board_io_ctrl_btn_debounce.sv
// rtl/board_io_ctrl_btn_debounce.sv - synchronising debouncer with stable level and rise pulse
module btn_debounce
    import board_io_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int            CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_DEPTH-1:0] r_sync;
    logic [CW-1:0]         r_cnt;
    logic                  r_level;
    logic                  r_rise;
    logic                  w_sample;
    logic                  w_differ;
    logic                  w_settle;

    assign w_sample = r_sync[SYNC_DEPTH-1];
    assign w_differ = (w_sample != r_level);
    assign w_settle = w_differ && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], btn};
            r_rise <= w_settle && w_sample;
            // Any sample agreeing with the stable level restarts the count.
            if (w_settle) begin
                r_level <= w_sample;
                r_cnt   <= '0;
            end else if (w_differ) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/board_io_ctrl.sv
// rtl/board_io_ctrl.sv - button debounce, divided CPU clock and inspection address select
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DIV       = DEF_DIV,
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int WRAP      = DEF_WRAP,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_step,
    input  logic              run_mode,
    input  logic              addr_mode,
    input  logic [ADDR_W-1:0] addr_sw,
    output logic              cpu_clk,
    output logic              cpu_tick,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CNT_W-1:0]  cyc_cnt
);

    localparam int                DW       = cnt_width(DIV);
    localparam logic [DW-1:0]     DIV_LAST = DW'(DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [SYNC_DEPTH-1:0] r_run_sync;
    logic [SYNC_DEPTH-1:0] r_amode_sync;
    logic [ADDR_W-1:0]     r_sw_s1;
    logic [ADDR_W-1:0]     r_sw_s2;
    logic                  w_run_s;
    logic                  w_amode_s;

    logic w_left_rise;
    logic w_right_rise;
    logic w_step_rise;

    clk_state_e        r_state;
    clk_state_e        w_state_nxt;
    logic [DW-1:0]     r_div_cnt;
    logic [DW-1:0]     w_div_nxt;
    logic              r_cpu_clk;
    logic              w_clk_nxt;
    logic              r_cpu_tick;
    logic              w_tick_nxt;
    logic              w_div_done;

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [CNT_W-1:0]  r_cyc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_sync   <= '0;
            r_amode_sync <= '0;
            r_sw_s1      <= '0;
            r_sw_s2      <= '0;
        end else begin
            r_run_sync   <= {r_run_sync[SYNC_DEPTH-2:0], run_mode};
            r_amode_sync <= {r_amode_sync[SYNC_DEPTH-2:0], addr_mode};
            r_sw_s1      <= addr_sw;
            r_sw_s2      <= r_sw_s1;
        end
    end

    assign w_run_s   = r_run_sync[SYNC_DEPTH-1];
    assign w_amode_s = r_amode_sync[SYNC_DEPTH-1];

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_left),
        .level (),
        .rise  (w_left_rise)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_right),
        .level (),
        .rise  (w_right_rise)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_step),
        .level (),
        .rise  (w_step_rise)
    );

    assign w_div_done = (r_div_cnt == DIV_LAST);

    // Mode is only sampled in IDLE and at the end of LOW, so a started period always completes.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cnt + DW'(1);
        w_clk_nxt   = r_cpu_clk;
        w_tick_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_div_nxt = '0;
                w_clk_nxt = 1'b0;
                if (w_run_s || w_step_rise) begin
                    w_state_nxt = HIGH;
                    w_clk_nxt   = 1'b1;
                    w_tick_nxt  = 1'b1;
                end
            end
            HIGH: begin
                if (w_div_done) begin
                    w_state_nxt = LOW;
                    w_clk_nxt   = 1'b0;
                    w_div_nxt   = '0;
                end
            end
            LOW: begin
                if (w_div_done) begin
                    w_div_nxt = '0;
                    if (w_run_s) begin
                        w_state_nxt = HIGH;
                        w_clk_nxt   = 1'b1;
                        w_tick_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_clk_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_clk_nxt   = 1'b0;
                w_div_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_div_cnt  <= '0;
            r_cpu_clk  <= 1'b0;
            r_cpu_tick <= 1'b0;
            r_cyc_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_div_cnt  <= w_div_nxt;
            r_cpu_clk  <= w_clk_nxt;
            r_cpu_tick <= w_tick_nxt;
            if (w_tick_nxt) begin
                r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
            end
        end
    end

    // Simultaneous left and right presses cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_mem_addr <= '0;
        end else begin
            if (w_right_rise && !w_left_rise) begin
                if ((WRAP != 0) || (r_ptr != ADDR_MAX)) begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                end
            end else if (w_left_rise && !w_right_rise) begin
                if ((WRAP != 0) || (r_ptr != '0)) begin
                    r_ptr <= r_ptr - ADDR_W'(1);
                end
            end
            r_mem_addr <= w_amode_s ? r_ptr : r_sw_s2;
        end
    end

    assign cpu_clk  = r_cpu_clk;
    assign cpu_tick = r_cpu_tick;
    assign mem_addr = r_mem_addr;
    assign cyc_cnt  = r_cyc_cnt;

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb/tb_board_io_ctrl.sv - directed and randomized bench for board_io_ctrl (wrap and saturate builds)
module tb_board_io_ctrl;

    localparam int AW = 6;
    localparam int DV = 4;
    localparam int DB = 8;
    localparam int CW = 16;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          btn_left  = 1'b0;
    logic          btn_right = 1'b0;
    logic          btn_step  = 1'b0;
    logic          run_mode  = 1'b0;
    logic          addr_mode = 1'b0;
    logic [AW-1:0] addr_sw   = '0;

    logic          cpu_clk  [2];
    logic          cpu_tick [2];
    logic [AW-1:0] mem_addr [2];
    logic [CW-1:0] cyc_cnt  [2];

    board_io_ctrl #(.ADDR_W(AW), .DIV(DV), .DB_CYCLES(DB), .WRAP(1), .CNT_W(CW)) u_wrap (
        .clk(clk), .rst_n(rst_n), .btn_left(btn_left), .btn_right(btn_right),
        .btn_step(btn_step), .run_mode(run_mode), .addr_mode(addr_mode), .addr_sw(addr_sw),
        .cpu_clk(cpu_clk[0]), .cpu_tick(cpu_tick[0]), .mem_addr(mem_addr[0]), .cyc_cnt(cyc_cnt[0])
    );

    board_io_ctrl #(.ADDR_W(AW), .DIV(DV), .DB_CYCLES(DB), .WRAP(0), .CNT_W(CW)) u_sat (
        .clk(clk), .rst_n(rst_n), .btn_left(btn_left), .btn_right(btn_right),
        .btn_step(btn_step), .run_mode(run_mode), .addr_mode(addr_mode), .addr_sw(addr_sw),
        .cpu_clk(cpu_clk[1]), .cpu_tick(cpu_tick[1]), .mem_addr(mem_addr[1]), .cyc_cnt(cyc_cnt[1])
    );

    always #5 clk = ~clk;

    int   n_run  = 0;
    int   n_fail = 0;
    int   rises     [2];
    int   high_len  [2];
    int   last_high [2];
    logic prev      [2];
    int   ptr_m     [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int next_ptr(input int p, input logic l, input logic r, input int wrap);
        int top = (1 << AW) - 1;
        if (l == r) return p;
        if (r) return wrap ? (p + 1) % (top + 1) : ((p == top) ? top : p + 1);
        return wrap ? (p + top) % (top + 1) : ((p == 0) ? 0 : p - 1);
    endfunction

    // One board cycle, sampled at the falling edge, with the tick/counter invariants.
    task automatic cyc1();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("tick_on_rise", 32'(cpu_tick[i]), 32'(cpu_clk[i] & ~prev[i]));
            if (cpu_clk[i] && !prev[i]) begin
                rises[i]++;
                high_len[i] = 0;
            end
            if (cpu_clk[i]) high_len[i]++;
            if (!cpu_clk[i] && prev[i]) last_high[i] = high_len[i];
            chk("cyc_vs_rises", 32'(cyc_cnt[i]), 32'(rises[i] % (1 << CW)));
            prev[i] = cpu_clk[i];
        end
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cyc1();
    endtask

    task automatic press(input logic l, input logic r, input int bounces);
        for (int b = 0; b < bounces; b++) begin
            btn_left = l; btn_right = r;
            cycles($urandom_range(1, DB - 2));
            btn_left = 1'b0; btn_right = 1'b0;
            cycles($urandom_range(1, 3));
        end
        btn_left = l; btn_right = r;
        cycles(DB + 4);
        btn_left = 1'b0; btn_right = 1'b0;
        cycles(DB + 4);
        ptr_m[0] = next_ptr(ptr_m[0], l, r, 1);
        ptr_m[1] = next_ptr(ptr_m[1], l, r, 0);
        chk("ptr_wrap", 32'(mem_addr[0]), 32'(ptr_m[0]));
        chk("ptr_sat", 32'(mem_addr[1]), 32'(ptr_m[1]));
    endtask

    initial begin
        int n;
        logic [AW-1:0] old_sw;
        logic          l;
        for (int i = 0; i < 2; i++) begin
            rises[i] = 0; high_len[i] = 0; last_high[i] = 0; prev[i] = 1'b0; ptr_m[i] = 0;
        end

        // Reset state, then free-run from release
        run_mode = 1'b1;
        cycles(3);
        for (int i = 0; i < 2; i++) begin
            chk("rst_clk", 32'(cpu_clk[i]), 0);
            chk("rst_tick", 32'(cpu_tick[i]), 0);
            chk("rst_addr", 32'(mem_addr[i]), 0);
            chk("rst_cyc", 32'(cyc_cnt[i]), 0);
        end
        rst_n = 1'b1;
        // Two sync edges then the rising edge: first high sample is cycle 3, period 2*DV.
        for (int c = 1; c <= 64; c++) begin
            cyc1();
            for (int i = 0; i < 2; i++) begin
                chk("run_clk", 32'(cpu_clk[i]), 32'((c >= 3) && (((c - 3) % (2 * DV)) < DV)));
                chk("run_tick", 32'(cpu_tick[i]), 32'((c >= 3) && (((c - 3) % (2 * DV)) == 0)));
                chk("run_cyc", 32'(cyc_cnt[i]), 32'((c >= 3) ? ((c - 3) / (2 * DV) + 1) : 0));
            end
        end

        // Leave free-run: the period in flight completes, then the clock parks low
        run_mode = 1'b0;
        cycles(20);
        chk("idle_clk", 32'(cpu_clk[0]), 0);
        chk("idle_cyc", 32'(cyc_cnt[0]), 8);

        // Single-step: one tick per press even when held long
        for (int p = 1; p <= 2; p++) begin
            btn_step = 1'b1;
            n = 0;
            do begin
                cyc1();
                n++;
            end while (!cpu_clk[0] && n < 40);
            // DB+2 edges to the debounced pulse, one more for the FSM to raise the clock
            chk("step_latency", 32'(n), 32'(DB + 3));
            cycles(30);
            btn_step = 1'b0;
            cycles(20);
            chk("step_high_len", 32'(last_high[0]), DV);
            chk("step_clk_low", 32'(cpu_clk[0]), 0);
            chk("step_cyc", 32'(cyc_cnt[0]), 32'(8 + p));
            chk("step_cyc_sat", 32'(cyc_cnt[1]), 32'(8 + p));
        end

        // Pointer: bounced right, then left past zero, then random presses
        addr_mode = 1'b1;
        cycles(5);
        chk("ptr_start", 32'(mem_addr[0]), 0);
        press(1'b0, 1'b1, 4);
        press(1'b1, 1'b0, 0);
        press(1'b1, 1'b0, 0);
        for (int k = 0; k < 6; k++) begin
            l = 1'($urandom_range(0, 1));
            press(l, ~l, $urandom_range(0, 3));
        end
        for (int k = 0; k < 70; k++) press(1'b0, 1'b1, 0);
        chk("sat_top", 32'(mem_addr[1]), 63);
        press(1'b1, 1'b1, 0);
        press(1'b1, 1'b1, 2);

        // Switch-sourced address
        addr_mode = 1'b0;
        cycles(5);
        chk("sw_src", 32'(mem_addr[0]), 32'(addr_sw));
        for (int k = 0; k < 5; k++) begin
            old_sw = addr_sw;
            addr_sw = (k == 0) ? AW'(6'h2A) : AW'($urandom_range(0, 63));
            cycles(2);
            chk("sw_old", 32'(mem_addr[1]), 32'(old_sw));
            cyc1();
            chk("sw_new", 32'(mem_addr[0]), 32'(addr_sw));
            chk("sw_new_sat", 32'(mem_addr[1]), 32'(addr_sw));
        end

        // Reset mid high phase
        run_mode = 1'b1;
        addr_mode = 1'b1;
        n = 0;
        do begin
            cyc1();
            n++;
        end while (!cpu_clk[0] && n < 40);
        chk("pre_rst_high", 32'(cpu_clk[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("arst_clk", 32'(cpu_clk[i]), 0);
            chk("arst_tick", 32'(cpu_tick[i]), 0);
            chk("arst_cyc", 32'(cyc_cnt[i]), 0);
            chk("arst_addr", 32'(mem_addr[i]), 0);
            rises[i] = 0; prev[i] = 1'b0; ptr_m[i] = 0;
        end
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        chk("rel_clk_low", 32'(cpu_clk[0]), 0);
        cyc1();
        chk("rel_clk_high", 32'(cpu_clk[0]), 1);
        chk("rel_cyc", 32'(cyc_cnt[0]), 1);
        chk("rel_ptr", 32'(mem_addr[0]), 32'(ptr_m[0]));
        chk("rel_ptr_sat", 32'(mem_addr[1]), 32'(ptr_m[1]));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Board-level I/O controller between the FPGA pins and the pipelined CPU core. It debounces the panel buttons and derives a divided CPU clock, with free-run and single-step modes. It also selects the data-memory inspection address from switches or from a button-stepped pointer with configurable wrap or saturation, and counts issued CPU cycles. All internal logic is synchronous to the board clock; nothing is clocked by a button.

## Interface
Parameters:
- ADDR_W, 6, width of memory inspection address
- DIV, 4, CPU clock half-period in clk cycles (≥1)
- DB_CYCLES, 1_000_000, consecutive stable samples required by debouncer (≥2)
- WRAP, 1, pointer behaviour: 1 = modular wrap, 0 = saturate at 0 / 2^ADDR_W-1
- CNT_W, 16, width of CPU cycle counter

Ports:
- clk  in  1  board clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_left  in  1  raw button, decrement pointer
- btn_right  in  1  raw button, increment pointer
- btn_step  in  1  raw button, issue one CPU clock in step mode
- run_mode  in  1  raw switch: 1 = free-run, 0 = single-step
- addr_mode  in  1  raw switch: 1 = button pointer, 0 = addr_sw
- addr_sw  in  ADDR_W  raw address switches
- cpu_clk  out  1  divided CPU clock, registered
- cpu_tick  out  1  one-clk pulse, high in the cycle cpu_clk first reads 1
- mem_addr  out  ADDR_W  registered inspection address to CPU
- cyc_cnt  out  CNT_W  number of CPU rising edges issued, wraps

## Operation
- Reset (async, rst_n=0): cpu_clk=0, cpu_tick=0, mem_addr=0, cyc_cnt=0, pointer=0, FSM=IDLE, divider count=0, all synchronisers and debouncers cleared (stable level 0).
- run_mode, addr_mode, addr_sw: each passed through 2-FF synchroniser before use.
- Debouncer per button: 2-FF sync → compare with stable level; differing sample increments counter, equal sample clears it. When the counter reaches DB_CYCLES-1 while differing, stable level is updated and counter cleared. A 0→1 stable transition gives a 1-cycle rise pulse.
- Clock FSM, states IDLE / HIGH / LOW:
  - IDLE: cpu_clk=0. If run_s=1 or step rise pulse → HIGH; cpu_clk←1, cpu_tick←1, cnt←0.
  - HIGH: cnt increments; at cnt=DIV-1 → LOW, cpu_clk←0, cnt←0.
  - LOW: cnt increments; at cnt=DIV-1 → HIGH (with tick) if run_s=1, else → IDLE.
  - Step pulses in HIGH/LOW are ignored, not queued. A mode change takes effect only at the LOW→next decision; a period in flight always completes.
- cyc_cnt increments on each cpu_tick, modulo 2^CNT_W.
- Pointer: right pulse only → +1; left pulse only → −1; both in same cycle → unchanged. WRAP=1: 2^ADDR_W-1+1→0, 0−1→2^ADDR_W-1. WRAP=0: holds at bounds.
- mem_addr ← addr_mode_s ? pointer : addr_sw_s, every cycle.

## Timing
- Run mode: cpu_clk period exactly 2·DIV clk cycles at 50% duty; cpu_tick every 2·DIV cycles.
- After reset release with run_mode held 1: synchroniser latency 2 cycles, then cpu_clk rises on the following edge (3rd edge after release).
- Step mode: one press → exactly one cpu_clk high pulse of DIV cycles followed by DIV low cycles, then IDLE.
- Button: rise pulse occurs DB_CYCLES+2 edges (±1 edge for sampling phase) after the raw edge. Bounces shorter than DB_CYCLES samples produce no pulse.
- Pointer updates on the edge after the pulse; mem_addr follows one edge later.
- Reset asserted mid-period: cpu_clk drops to 0 asynchronously, no tick emitted, cyc_cnt cleared.

## Structure
- Package board_io_pkg: clock FSM state enum (IDLE, HIGH, LOW), default parameter constants, sync depth constant (2).
- Sub-module btn_debounce (params DB_CYCLES; ports clk, rst_n, btn, level, rise), instantiated three times.
- Counter widths: divider $clog2(DIV), debounce $clog2(DB_CYCLES).

## Test plan
(Bench uses DIV=4, DB_CYCLES=8, ADDR_W=6.)
- run_mode=1 from reset, 64 cycles → cpu_clk period 8, duty 4/4; cyc_cnt=7 or 8 depending on release phase, checked exactly against tick count.
- run_mode=0, clean step press → exactly one tick, cpu_clk high 4 cycles; second press during HIGH ignored, cyc_cnt=1.
- btn_right bouncing (3-cycle glitches ×4) then stable 20 cycles → single +1; pointer 0→1, mem_addr=1 with addr_mode=1.
- WRAP=1: left from 0 → 63; WRAP=0: left from 0 → 0, right ×70 → 63.
- Left and right pulses aligned in same cycle → pointer unchanged; addr_mode=0, addr_sw=6'h2A → mem_addr=0x2A after 3 edges.
- rst_n pulled low while cpu_clk=1 → cpu_clk, cyc_cnt, mem_addr immediately 0; FSM restarts from IDLE after release.
